instr_encoder: RTL and testbench

- Inverse of the decode path's immediate generator: packs opcode, register fields, funct fields and a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Streams encoded words with a word address to the instruction-memory loader, one word per handshake.
- Used by the on-chip program loader and by the test harness to build CNN kernel programs without an external assembler.

---
 rtl/rv_isa_pkg.sv | 46 ++++
 rtl/instr_encoder_imm_pack.sv | 37 +++
 rtl/instr_encoder.sv | 118 +++++++++++
 tb/tb_instr_encoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I opcode, format and immediate-width definitions shared by the encoder
// and the decode-side immediate generator.
package rv_isa_pkg;

   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_SB   = 7'b1100011;
   localparam logic [6:0] OP_I_LD = 7'b0000011;
   localparam logic [6:0] OP_J    = 7'b1101111;
   localparam logic [6:0] OP_JR   = 7'b1100111;
   localparam logic [6:0] OP_R    = 7'b0110011;

   localparam int W_I  = 12;
   localparam int W_SB = 13;
   localparam int W_J  = 21;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_SB,
      FMT_J,
      FMT_BAD
   } fmt_e;

   function automatic fmt_e op_fmt(input logic [6:0] op);
      fmt_e f;
      case (op)
         OP_R:                 f = FMT_R;
         OP_I, OP_I_LD, OP_JR: f = FMT_I;
         OP_S:                 f = FMT_S;
         OP_SB:                f = FMT_SB;
         OP_J:                 f = FMT_J;
         default:              f = FMT_BAD;
      endcase
      return f;
   endfunction

   // True when imm is representable as a k-bit two's-complement value.
   function automatic logic imm_fits(input logic [31:0] imm, input int k);
      logic [31:0] hi;
      hi = 32'($signed(imm) >>> (k - 1));
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational immediate placement: scatters imm into its format-specific
// bit positions and flags whether the value is encodable for that opcode.
module imm_pack
   import rv_isa_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [31:0] imm_i,
   output logic [31:0] imm_bits_o,
   output logic        range_ok_o
);

   always_comb begin
      imm_bits_o = '0;
      range_ok_o = 1'b0;
      case (op_fmt(opcode_i))
         FMT_R: range_ok_o = 1'b1;
         FMT_I: begin
            imm_bits_o = {imm_i[11:0], 20'b0};
            range_ok_o = imm_fits(imm_i, W_I);
         end
         FMT_S: begin
            imm_bits_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
            range_ok_o = imm_fits(imm_i, W_I);
         end
         FMT_SB: begin
            imm_bits_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
            range_ok_o = imm_fits(imm_i, W_SB) && !imm_i[0];
         end
         FMT_J: begin
            imm_bits_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
            range_ok_o = imm_fits(imm_i, W_J) && !imm_i[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder streaming {word, byte address}; 1-cycle latency,
// single output register, in_ready = !out_valid || out_ready.
module instr_encoder
   import rv_isa_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              load_base,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              err_clr,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_count
);

   logic              out_valid_q, out_valid_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_cur;
   logic              sticky_q, sticky_d;
   logic [CNT_W-1:0]  errs_q, errs_d;

   logic [31:0] imm_bits;
   logic        range_ok;
   logic [31:0] word;
   logic        accept, good, rej;

   imm_pack u_imm_pack (
      .opcode_i   (in_opcode),
      .imm_i      (in_imm),
      .imm_bits_o (imm_bits),
      .range_ok_o (range_ok)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign good     = accept && range_ok;
   assign rej      = accept && !range_ok;

   always_comb begin
      word = '0;
      case (op_fmt(in_opcode))
         FMT_R:         word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I:         word = {12'b0, in_rs1, in_funct3, in_rd, in_opcode} | imm_bits;
         FMT_S, FMT_SB: word = {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode} | imm_bits;
         FMT_J:         word = {20'b0, in_rd, in_opcode} | imm_bits;
         default: ;
      endcase
   end

   // A same-cycle load_base is seen by the word accepted in that cycle.
   assign pc_cur = load_base ? (base_addr & ~ADDR_W'(3)) : pc_q;

   always_comb begin
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      addr_d      = addr_q;
      pc_d        = pc_cur;
      sticky_d    = sticky_q;
      errs_d      = errs_q;
      if (good) begin
         out_valid_d = 1'b1;
         instr_d     = word;
         addr_d      = pc_cur;
         pc_d        = pc_cur + ADDR_W'(4);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (rej) begin
         sticky_d = 1'b1;
         if (err_clr)          errs_d = CNT_W'(1);
         else if (errs_q != '1) errs_d = errs_q + CNT_W'(1);
      end else if (err_clr) begin
         sticky_d = 1'b0;
         errs_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         addr_q      <= '0;
         pc_q        <= '0;
         sticky_q    <= 1'b0;
         errs_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         addr_q      <= addr_d;
         pc_q        <= pc_d;
         sticky_q    <= sticky_d;
         errs_q      <= errs_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_instr  = instr_q;
   assign out_addr   = addr_q;
   assign err_sticky = sticky_q;
   assign err_count  = errs_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed encodings.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        load_base;
   logic [31:0] base_addr;
   logic        err_clr;
   logic        err_sticky;
   logic [7:0]  err_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(32), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_funct3  (in_funct3),
      .in_funct7  (in_funct7),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .load_base  (load_base),
      .base_addr  (base_addr),
      .err_clr    (err_clr),
      .err_sticky (err_sticky),
      .err_count  (err_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
      in_valid  = 1'b1;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = 7'd0;
      in_imm    = imm;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      load_base = 1'b0; base_addr = '0; err_clr = 1'b0;
      #12;
      chk("rst_valid",  {31'd0, out_valid}, 32'd0);
      chk("rst_instr",  out_instr, 32'd0);
      chk("rst_addr",   out_addr, 32'd0);
      chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
      chk("rst_count",  {24'd0, err_count}, 32'd0);
      rst_n = 1'b1;
      tick();

      // ADDI x1,x0,-1 with same-cycle load_base (low bits of base ignored)
      load_base = 1'b1; base_addr = 32'h103;
      req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
      tick();
      load_base = 1'b0;
      chk("addi_valid", {31'd0, out_valid}, 32'd1);
      chk("addi_instr", out_instr, 32'hFFF0_0093);
      chk("addi_addr",  out_addr, 32'h100);

      req(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8);
      tick();
      chk("sw_instr", out_instr, 32'h0020_A423);
      chk("sw_addr",  out_addr, 32'h104);

      req(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
      tick();
      chk("beq_instr", out_instr, 32'hFE00_0EE3);
      chk("beq_addr",  out_addr, 32'h108);
      req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
      tick();
      chk("jal_instr", out_instr, 32'h0010_00EF);
      chk("jal_addr",  out_addr, 32'h10C);
      in_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // rejection cases
      req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
      tick();
      chk("rej_addi_valid", {31'd0, out_valid}, 32'd0);
      chk("rej_addi_count", {24'd0, err_count}, 32'd1);
      chk("rej_addi_sticky", {31'd0, err_sticky}, 32'd1);
      req(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd6);
      tick();
      chk("beq6_valid", {31'd0, out_valid}, 32'd1);
      chk("beq6_instr", out_instr, 32'h0000_0363);
      chk("beq6_addr",  out_addr, 32'h110);
      req(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd5);
      tick();
      chk("beq5_valid", {31'd0, out_valid}, 32'd0);
      chk("beq5_count", {24'd0, err_count}, 32'd2);
      chk("beq5_sticky", {31'd0, err_sticky}, 32'd1);
      in_valid = 1'b0; err_clr = 1'b1;
      tick();
      chk("clr_count",  {24'd0, err_count}, 32'd0);
      chk("clr_sticky", {31'd0, err_sticky}, 32'd0);
      // err_clr together with a rejection: rejection wins
      req(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
      tick();
      chk("clrrej_count",  {24'd0, err_count}, 32'd1);
      chk("clrrej_sticky", {31'd0, err_sticky}, 32'd1);
      in_valid = 1'b0;
      tick();
      err_clr = 1'b0;

      // backpressure
      out_ready = 1'b0;
      req(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd5);
      tick();
      chk("bp_first_instr", out_instr, 32'h0050_0113);
      chk("bp_first_addr",  out_addr, 32'h114);
      req(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd7);
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
         chk("bp_hold_instr", out_instr, 32'h0050_0113);
         chk("bp_hold_addr",  out_addr, 32'h114);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("bp_second_instr", out_instr, 32'h0070_0193);
      chk("bp_second_addr",  out_addr, 32'h118);

      // load_base while a word is held keeps the held address
      in_valid = 1'b0; out_ready = 1'b0;
      load_base = 1'b1; base_addr = 32'h200;
      tick();
      load_base = 1'b0;
      chk("lb_held_addr",  out_addr, 32'h118);
      chk("lb_held_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      req(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 32'd1);
      tick();
      chk("lb_new_instr", out_instr, 32'h0010_0213);
      chk("lb_new_addr",  out_addr, 32'h200);
      tick();
      chk("lb_next_addr", out_addr, 32'h204);
      in_valid = 1'b0;
      tick();

      // error counter saturation; address must not move
      req(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
      for (int i = 0; i < 256; i++) tick();
      chk("sat_count", {24'd0, err_count}, 32'd255);
      tick();
      chk("sat_hold",  {24'd0, err_count}, 32'd255);
      chk("sat_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
      tick();
      in_valid = 1'b0;
      chk("after_sat_addr",  out_addr, 32'h208);
      chk("after_sat_instr", out_instr, 32'hFFF0_0093);

      // asynchronous reset while a word is held
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_addr",  out_addr, 32'd0);
      chk("arst_count", {24'd0, err_count}, 32'd0);
      tick();
      rst_n = 1'b1; out_ready = 1'b1;
      tick();
      req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("post_rst_instr", out_instr, 32'h0010_0093);
      chk("post_rst_addr",  out_addr, 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
